// File: rtl/fadd_pkg.sv
// Shared constants, types and helpers for the
// floating-point add scheduler and its adder.
package fadd_pkg;

  localparam int   FADD_LATENCY = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DRAINED
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [1:0] idx;
  } tag_t;

  function automatic logic [4:0] clz27(
    input logic [26:0] v
  );
    clz27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) clz27 = 5'(26 - i);
  endfunction

endpackage

// File: rtl/fadd_sched_fadd.sv
// Four-stage IEEE-754 single adder, round to
// nearest even, denormals kept, NaN quieted.
module PipelinedFAdd
  import fadd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic [31:0] result
);

  logic [31:0] bx, l, s, spv0;
  logic        na, nb, ia, ib;

  always_comb begin
    bx = {b[31] ^ (op == OP_SUB), b[30:0]};
    l  = (bx[30:0] > a[30:0]) ? bx : a;
    s  = (bx[30:0] > a[30:0]) ? a : bx;
    na = (&a[30:23]) & (|a[22:0]);
    nb = (&b[30:23]) & (|b[22:0]);
    ia = (&a[30:23]) & ~(|a[22:0]);
    ib = (&b[30:23]) & ~(|b[22:0]);
    spv0 = 32'h7fc0_0000;
    if (na)
      spv0 = a | 32'h0040_0000;
    else if (nb)
      spv0 = b | 32'h0040_0000;
    else if (ia && ib && (a[31] != bx[31]))
      spv0 = 32'h7fc0_0000;
    else if (ia)
      spv0 = a;
    else if (ib)
      spv0 = bx;
  end

  logic        s1_sl, s1_sub, s1_sp;
  logic [7:0]  s1_el, s1_es;
  logic [23:0] s1_ml, s1_ms;
  logic [31:0] s1_spv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sl  <= 1'b0;
      s1_sub <= 1'b0;
      s1_sp  <= 1'b0;
      s1_el  <= '0;
      s1_es  <= '0;
      s1_ml  <= '0;
      s1_ms  <= '0;
      s1_spv <= '0;
    end else begin
      s1_sl  <= l[31];
      s1_sub <= l[31] ^ s[31];
      s1_sp  <= na | nb | ia | ib;
      s1_el  <= (l[30:23] == 0) ? 8'd1 : l[30:23];
      s1_es  <= (s[30:23] == 0) ? 8'd1 : s[30:23];
      s1_ml  <= {|l[30:23], l[22:0]};
      s1_ms  <= {|s[30:23], s[22:0]};
      s1_spv <= spv0;
    end
  end

  // align the smaller operand, keeping a sticky bit
  logic [7:0]  d;
  logic [26:0] wide, shf, ms_al;
  logic        sticky;

  always_comb begin
    d    = s1_el - s1_es;
    wide = {s1_ms, 3'b000};
    if (d >= 8'd27) begin
      shf    = '0;
      sticky = |s1_ms;
    end else begin
      shf    = wide >> d;
      sticky = |(wide & ((27'd1 << d) - 27'd1));
    end
    ms_al = {shf[26:1], shf[0] | sticky};
  end

  logic        s2_sign, s2_sub, s2_sp;
  logic [7:0]  s2_e;
  logic [26:0] s2_ml, s2_ms;
  logic [31:0] s2_spv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_sign <= 1'b0;
      s2_sub  <= 1'b0;
      s2_sp   <= 1'b0;
      s2_e    <= '0;
      s2_ml   <= '0;
      s2_ms   <= '0;
      s2_spv  <= '0;
    end else begin
      s2_sign <= s1_sl;
      s2_sub  <= s1_sub;
      s2_sp   <= s1_sp;
      s2_e    <= s1_el;
      s2_ml   <= {s1_ml, 3'b000};
      s2_ms   <= ms_al;
      s2_spv  <= s1_spv;
    end
  end

  logic        s3_sign, s3_sub, s3_sp;
  logic [7:0]  s3_e;
  logic [27:0] s3_sum;
  logic [31:0] s3_spv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_sign <= 1'b0;
      s3_sub  <= 1'b0;
      s3_sp   <= 1'b0;
      s3_e    <= '0;
      s3_sum  <= '0;
      s3_spv  <= '0;
    end else begin
      s3_sign <= s2_sign;
      s3_sub  <= s2_sub;
      s3_sp   <= s2_sp;
      s3_e    <= s2_e;
      s3_sum  <= s2_sub ?
                 {1'b0, s2_ml} - {1'b0, s2_ms} :
                 {1'b0, s2_ml} + {1'b0, s2_ms};
      s3_spv  <= s2_spv;
    end
  end

  logic [9:0]  e;
  logic [26:0] v;
  logic [4:0]  lz, sh;
  logic        rnd;
  logic [24:0] m;
  logic [31:0] res;

  always_comb begin
    e = {2'b00, s3_e};
    v = s3_sum[26:0];
    if (s3_sum[27]) begin
      v = {s3_sum[27:2], |s3_sum[1:0]};
      e = e + 10'd1;
    end
    lz = clz27(v);
    sh = ({5'b0, lz} < e) ? lz : 5'(e - 10'd1);
    v  = v << sh;
    e  = v[26] ? e - {5'b0, sh} : 10'd0;
    rnd = v[2] & (v[1] | v[0] | v[3]);
    m   = {1'b0, v[26:3]} + {24'b0, rnd};
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end else if (e == 10'd0 && m[23]) begin
      e = 10'd1;
    end
    if (s3_sp)
      res = s3_spv;
    else if (s3_sum == '0)
      res = {s3_sign & ~s3_sub, 31'b0};
    else if (e >= 10'd255)
      res = {s3_sign, 8'hff, 23'b0};
    else
      res = {s3_sign, e[7:0], m[22:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) result <= '0;
    else     result <= res;
  end

endmodule

// File: rtl/fadd_sched.sv
// Round-robin scheduler sharing one pipelined
// adder between requesters, with drain control.
module fadd_sched
  import fadd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int LATENCY = FADD_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ-1:0]   req_op,
  output logic [NUM_REQ-1:0]   resp_valid,
  output logic [31:0]          resp_result,
  input  logic                 drain,
  output logic                 drained,
  output logic [2:0]           inflight
);

  state_t     state, state_nx;
  logic [1:0] ptr, win;
  logic       found;
  tag_t       tags [LATENCY];
  logic [31:0] op_a, op_b;
  logic       op_s;
  logic       rsp;

  always_comb begin
    int j;
    j = 0;
    req_ready = '0;
    win = ptr;
    found = 1'b0;
    if (!rst && state == RUN && !drain) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        j = (int'(ptr) + k) % NUM_REQ;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          win = 2'(j);
          req_ready[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    op_a = req_a[32*int'(win) +: 32];
    op_b = req_b[32*int'(win) +: 32];
    op_s = req_op[win];
  end

  PipelinedFAdd u_fadd (
    .clk    (clk),
    .rst    (rst),
    .a      (op_a),
    .b      (op_b),
    .op     (op_s),
    .result (resp_result)
  );

  assign rsp = tags[LATENCY-1].vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++)
        tags[k] <= '0;
      ptr      <= '0;
      inflight <= '0;
      state    <= RUN;
    end else begin
      tags[0] <= {found, win};
      for (int k = 1; k < LATENCY; k++)
        tags[k] <= tags[k-1];
      if (found)
        ptr <= 2'((int'(win) + 1) % NUM_REQ);
      inflight <= inflight + {2'b0, found}
                  - {2'b0, rsp};
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:
        if (drain) state_nx = DRAIN;
      DRAIN:
        if (!drain)
          state_nx = RUN;
        else if (inflight == 3'd0)
          state_nx = DRAINED;
      DRAINED:
        if (!drain) state_nx = RUN;
      default:
        state_nx = RUN;
    endcase
  end

  always_comb begin
    resp_valid = '0;
    for (int k = 0; k < NUM_REQ; k++)
      resp_valid[k] = !rst && rsp &&
                      tags[LATENCY-1].idx == 2'(k);
  end

  assign drained = !rst && state == DRAINED;

endmodule

// File: tb/tb_fadd_sched.sv
// Directed and random checks of fadd_sched against
// an integer-arithmetic reference model.
module tb_fadd_sched;
  import fadd_pkg::*;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready;
  logic [N-1:0]    req_op, resp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     resp_result;
  logic            drain, drained;
  logic [2:0]      inflight;

  fadd_sched #(
    .NUM_REQ(N),
    .LATENCY(FADD_LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_result(resp_result),
    .drain      (drain),
    .drained    (drained),
    .inflight   (inflight)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    int          due;
    logic [31:0] expv;
    bit          nan;
  } ent_t;

  ent_t q[$];
  int   va[N], vb[N];
  bit   vnan[N];
  int   ptr, mst, cyc;
  int   npass, ntot;

  function automatic logic [31:0] int2f(int x);
    int mag, p;
    if (x == 0) return 32'h0;
    mag = (x < 0) ? -x : x;
    p = 0;
    for (int k = 0; k < 31; k++)
      if (mag >= (1 << k)) p = k;
    return {x < 0, 8'(127 + p),
            23'((mag << (23 - p)) & 32'h7f_ffff)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, expv);
  endtask

  task automatic set_int(int i, int a, int b,
                         logic op);
    req_a[32*i +: 32] = int2f(a);
    req_b[32*i +: 32] = int2f(b);
    req_op[i] = op;
    va[i] = a;
    vb[i] = b;
    vnan[i] = 1'b0;
  endtask

  task automatic set_rand(int i);
    set_int(i,
      int'($urandom_range(0, 2000000)) - 1000000,
      int'($urandom_range(0, 2000000)) - 1000000,
      logic'($urandom_range(0, 1)));
  endtask

  task automatic step();
    logic [N-1:0] er, ev;
    int   w, sz0;
    bit   got;
    ent_t e, ne;
    #1;
    er = '0;
    w  = -1;
    if (mst == 0 && !drain)
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(ptr + k) % N])
          w = (ptr + k) % N;
    if (w >= 0) er[w] = 1'b1;
    chk("ready", 32'(req_ready), 32'(er));
    sz0 = q.size();
    chk("inflight", 32'(inflight), 32'(sz0));
    chk("drained", 32'(drained), 32'(mst == 2));
    ev  = '0;
    got = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      ev[e.idx] = 1'b1;
      got = 1'b1;
    end
    chk("resp_valid", 32'(resp_valid), 32'(ev));
    if (got && e.nan)
      chk("nan_result",
          32'(&resp_result[30:23] &&
              |resp_result[22:0]), 32'd1);
    else if (got)
      chk("result", resp_result, e.expv);
    if (w >= 0) begin
      ne.idx = w;
      ne.due = cyc + FADD_LATENCY;
      ne.nan = vnan[w];
      ne.expv = req_op[w] ?
                int2f(va[w] - vb[w]) :
                int2f(va[w] + vb[w]);
      q.push_back(ne);
      ptr = (w + 1) % N;
    end
    case (mst)
      0: if (drain) mst = 1;
      1: if (!drain) mst = 0;
         else if (sz0 == 0) mst = 2;
      default: if (!drain) mst = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_cycles(int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_resp", 32'(resp_valid), 32'd0);
      chk("rst_drained", 32'(drained), 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    q.delete();
    ptr = 0;
    mst = 0;
    cyc = 0;
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    rst   = 1'b1;
    drain = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    for (int i = 0; i < N; i++) set_int(i, 0, 0, OP_ADD);
    @(posedge clk);
    #1;
    req_valid = '1;
    reset_cycles(2);
    idle(2);

    // 1.0 + 2.0 on requester 0
    set_int(0, 1, 2, OP_ADD);
    req_valid = 2'b01;
    step();
    idle(6);

    // 10.0 - 2.0 on requester 1
    set_int(1, 10, 2, OP_SUB);
    req_valid = 2'b10;
    step();
    idle(6);

    // contention
    req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      set_rand(0);
      set_rand(1);
      step();
    end
    idle(6);

    // drain with three in flight
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      set_rand(0);
      set_rand(1);
      step();
    end
    drain = 1'b1;
    for (int i = 0; i < 8; i++) step();
    drain = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand(0);
      set_rand(1);
      step();
    end
    idle(6);

    // reset with two in flight, pointer at 1
    set_rand(1);
    req_valid = 2'b10;
    step();
    set_rand(0);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    reset_cycles(1);
    idle(4);
    set_rand(0);
    set_rand(1);
    req_valid = 2'b11;
    step();
    idle(6);

    // NaN operand routed to requester 1
    req_a[63:32] = 32'h7fc0_0001;
    req_b[63:32] = 32'h4120_0000;
    req_op[1] = OP_ADD;
    vnan[1] = 1'b1;
    req_valid = 2'b10;
    step();
    idle(6);

    // random traffic with occasional drain
    for (int i = 0; i < 80; i++) begin
      set_rand(0);
      set_rand(1);
      req_valid = N'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0)
        drain = ~drain;
      step();
    end
    drain = 1'b0;
    idle(8);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
